// File: rtl/qos_pkg.sv
// Shared QoS types for the memory arbiter and its helpers.
package qos_pkg;

    localparam int QOS_WEIGHT_W = 8;
    localparam int QOS_LAT_W    = 16;

    typedef enum logic [1:0] {
        QOS_LOW      = 2'd0,
        QOS_MEDIUM   = 2'd1,
        QOS_HIGH     = 2'd2,
        QOS_CRITICAL = 2'd3
    } qos_level_e;

    // Per-request descriptor supplied by the per-core QoS policy engine.
    typedef struct packed {
        qos_level_e              level;
        logic                    urgent;
        logic [QOS_WEIGHT_W-1:0] weight;
        logic [QOS_LAT_W-1:0]    max_latency_cycles;
    } qos_config_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2
    } qos_arb_state_e;

    // Arbitration key; field order makes escalation dominate level, level dominate credit.
    typedef struct packed {
        logic       escalated;
        qos_level_e level;
        logic       has_credit;
    } qos_arb_key_t;

endpackage

// File: rtl/qos_rr_pick.sv
// Rotating find-first-set: first set bit of mask_i at or after ptr_i, wrapping around.
module qos_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IDX_W = $clog2(N);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Walk the mask starting from the pointer; first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr_i) + k) % N);
            if (!found && mask_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/qos_mem_arbiter.sv
// QoS-aware arbiter sharing one memory port, single outstanding transaction.
import qos_pkg::*;

module qos_mem_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AGE_W    = 16,
    parameter int CREDIT_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         qos_enable_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata_i,
    input  logic [NUM_REQ-1:0]           req_we_i,
    input  qos_config_t [NUM_REQ-1:0]    req_qos_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [DATA_W-1:0]            rsp_rdata_o,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [ADDR_W-1:0]            mem_addr_o,
    output logic [DATA_W-1:0]            mem_wdata_o,
    output logic                         mem_we_o,
    output qos_config_t                  mem_qos_o,
    input  logic                         mem_rsp_valid_i,
    input  logic [DATA_W-1:0]            mem_rsp_rdata_i,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic [NUM_REQ-1:0]           lat_violation_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    qos_arb_state_e                   state_q, state_d;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                 grant_id_q, grant_id_d;
    logic [ADDR_W-1:0]                mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]                mem_wdata_q, mem_wdata_d;
    logic                             mem_we_q, mem_we_d;
    qos_config_t                      mem_qos_q, mem_qos_d;
    logic [NUM_REQ-1:0][AGE_W-1:0]    age_q, age_d;
    logic [NUM_REQ-1:0][CREDIT_W-1:0] credit_q, credit_d;
    logic [NUM_REQ-1:0]               fired_q, fired_d;

    logic [ADDR_W-1:0]   addr_arr   [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr  [NUM_REQ];
    logic [CREDIT_W-1:0] weight_arr [NUM_REQ];
    qos_arb_key_t        key_arr    [NUM_REQ];
    qos_arb_key_t        max_key;
    logic [NUM_REQ-1:0]  has_credit, escalated, viol, cand_mask, accept_mask;
    logic [NUM_REQ-1:0]  qos_grant, rr_grant, win_grant;
    logic [IDX_W-1:0]    qos_idx, rr_idx, win_idx;
    logic                accept, reload;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign addr_arr[gi]   = req_addr_i[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]  = req_wdata_i[gi*DATA_W +: DATA_W];
            assign weight_arr[gi] = CREDIT_W'(req_qos_i[gi].weight);
            assign has_credit[gi] = (credit_q[gi] != '0);
            assign escalated[gi]  = req_qos_i[gi].urgent |
                                    (32'(age_q[gi]) >= 32'(req_qos_i[gi].max_latency_cycles));
            assign key_arr[gi]    = '{escalated:  escalated[gi],
                                      level:      req_qos_i[gi].level,
                                      has_credit: has_credit[gi]};
            // Fires only on the exact cycle the wait hits the limit, and only once per request.
            assign viol[gi]       = qos_enable_i & req_valid_i[gi] & ~fired_q[gi] &
                                    (32'(age_q[gi]) == 32'(req_qos_i[gi].max_latency_cycles));
        end
    endgenerate

    // Highest key among valid requesters, then the set of requesters tied at that key.
    always_comb begin
        max_key   = '0;
        cand_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid_i[i] && (key_arr[i] > max_key)) begin
                max_key = key_arr[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_mask[i] = req_valid_i[i] && (key_arr[i] == max_key);
        end
    end

    qos_rr_pick #(.N(NUM_REQ)) u_pick_qos (
        .mask_i  (cand_mask),
        .ptr_i   (rr_ptr_q),
        .grant_o (qos_grant),
        .idx_o   (qos_idx)
    );

    qos_rr_pick #(.N(NUM_REQ)) u_pick_rr (
        .mask_i  (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    assign win_grant   = qos_enable_i ? qos_grant : rr_grant;
    assign win_idx     = qos_enable_i ? qos_idx   : rr_idx;
    assign accept_mask = accept ? win_grant : '0;
    assign reload      = (state_q == ARB_IDLE) && ((req_valid_i & has_credit) == '0);

    // Transaction FSM: accept in IDLE, present to memory in ISSUE, route response in WAIT_RSP.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_qos_d   = mem_qos_q;
        accept      = 1'b0;
        req_ready_o = '0;
        rsp_valid_o = '0;
        case (state_q)
            ARB_IDLE: begin
                if (|req_valid_i) begin
                    accept      = 1'b1;
                    req_ready_o = win_grant;
                    grant_id_d  = win_idx;
                    rr_ptr_d    = (int'(win_idx) == NUM_REQ-1) ? '0 : win_idx + 1'b1;
                    mem_addr_d  = addr_arr[win_idx];
                    mem_wdata_d = wdata_arr[win_idx];
                    mem_we_d    = req_we_i[win_idx];
                    mem_qos_d   = req_qos_i[win_idx];
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = ARB_WAIT_RSP;
                end
            end
            ARB_WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    rsp_valid_o[grant_id_q] = 1'b1;
                    state_d                 = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Per-requester aging, weighted credit and violation bookkeeping.
    always_comb begin
        age_d    = age_q;
        credit_d = credit_q;
        fired_d  = fired_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid_i[i] || accept_mask[i]) begin
                age_d[i]   = '0;
                fired_d[i] = 1'b0;
            end else begin
                if (age_q[i] != '1) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
                if (viol[i]) begin
                    fired_d[i] = 1'b1;
                end
            end
            // A reload coinciding with an accept charges the winner immediately.
            if (reload) begin
                if (accept_mask[i]) begin
                    credit_d[i] = (weight_arr[i] == '0) ? '0 : weight_arr[i] - 1'b1;
                end else begin
                    credit_d[i] = weight_arr[i];
                end
            end else if (accept_mask[i] && has_credit[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end
        end
    end

    // State and bookkeeping registers; asynchronous reset drops any transaction in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_qos_q   <= '0;
            age_q       <= '0;
            credit_q    <= '0;
            fired_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_qos_q   <= mem_qos_d;
            age_q       <= age_d;
            credit_q    <= credit_d;
            fired_q     <= fired_d;
        end
    end

    assign mem_req_valid_o = (state_q == ARB_ISSUE);
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_we_o        = mem_we_q;
    assign mem_qos_o       = mem_qos_q;
    assign grant_id_o      = grant_id_q;
    assign lat_violation_o = viol;
    assign rsp_rdata_o     = ((state_q == ARB_WAIT_RSP) && mem_rsp_valid_i) ? mem_rsp_rdata_i : '0;

endmodule

// File: tb/tb_qos_mem_arbiter.sv
// Randomized bench for qos_mem_arbiter against a rule-level reference model.
module tb_qos_mem_arbiter;
    import qos_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int AGE_W    = 16;
    localparam int CREDIT_W = 8;
    localparam int AGE_SAT  = (1 << AGE_W) - 1;

    logic                       clk_i = 1'b0;
    logic                       rst_i = 1'b1;
    logic                       qos_enable_i = 1'b0;
    logic [NUM_REQ-1:0]         req_valid_i = '0;
    logic [NUM_REQ-1:0]         req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr_i = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_wdata_i = '0;
    logic [NUM_REQ-1:0]         req_we_i = '0;
    qos_config_t [NUM_REQ-1:0]  req_qos_i = '0;
    logic [NUM_REQ-1:0]         rsp_valid_o;
    logic [DATA_W-1:0]          rsp_rdata_o;
    logic                       mem_req_valid_o;
    logic                       mem_req_ready_i = 1'b0;
    logic [ADDR_W-1:0]          mem_addr_o;
    logic [DATA_W-1:0]          mem_wdata_o;
    logic                       mem_we_o;
    qos_config_t                mem_qos_o;
    logic                       mem_rsp_valid_i = 1'b0;
    logic [DATA_W-1:0]          mem_rsp_rdata_i = '0;
    logic [1:0]                 grant_id_o;
    logic [NUM_REQ-1:0]         lat_violation_o;

    qos_mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AGE_W(AGE_W), .CREDIT_W(CREDIT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .qos_enable_i(qos_enable_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_we_i(req_we_i),
        .req_qos_i(req_qos_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_qos_o(mem_qos_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_rdata_i(mem_rsp_rdata_i), .grant_id_o(grant_id_o),
        .lat_violation_o(lat_violation_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // Stimulus knobs
    int new_pct, drop_pct, ready_pct, rsp_pct, qos_mode;
    bit fixed_qos;
    logic [NUM_REQ-1:0] req_en;

    // Reference model: transaction phase (0 free, 1 offered to memory, 2 awaiting data)
    int          m_phase, m_ptr, m_gid;
    int          m_age    [NUM_REQ];
    int          m_credit [NUM_REQ];
    bit          m_fired  [NUM_REQ];
    bit          m_won    [NUM_REQ];
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    qos_config_t m_qos;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_gid = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_qos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_age[i] = 0; m_credit[i] = 0; m_fired[i] = 0; m_won[i] = 0;
        end
    endtask

    // Compute expected outputs from the rules, compare, then advance the model one clock.
    task automatic eval_cycle();
        int score [NUM_REQ];
        int best, win, wt;
        bit reload, esc;
        logic [NUM_REQ-1:0] e_ready, e_rsp, e_viol;
        logic [DATA_W-1:0]  e_rdata;
        e_ready = '0; e_rsp = '0; e_viol = '0; e_rdata = '0; win = -1; best = -1;
        if (rst_i) model_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            esc = req_qos_i[i].urgent || (m_age[i] >= int'(req_qos_i[i].max_latency_cycles));
            score[i] = (esc ? 8 : 0) + 2 * int'(req_qos_i[i].level) + (m_credit[i] > 0 ? 1 : 0);
            if (!qos_enable_i) score[i] = 0;
            if (qos_enable_i && req_valid_i[i] && !m_fired[i] &&
                m_age[i] == int'(req_qos_i[i].max_latency_cycles)) e_viol[i] = 1'b1;
            if (req_valid_i[i] && score[i] > best) best = score[i];
        end
        if (m_phase == 0 && req_valid_i != '0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int j;
                j = (m_ptr + k) % NUM_REQ;
                if (win < 0 && req_valid_i[j] && score[j] == best) win = j;
            end
            e_ready[win] = 1'b1;
        end
        if (m_phase == 2 && mem_rsp_valid_i) begin
            e_rsp[m_gid] = 1'b1;
            e_rdata      = mem_rsp_rdata_i;
        end
        check_eq("req_ready",   64'(req_ready_o),     64'(e_ready));
        check_eq("rsp_valid",   64'(rsp_valid_o),     64'(e_rsp));
        check_eq("rsp_rdata",   64'(rsp_rdata_o),     64'(e_rdata));
        check_eq("mem_valid",   64'(mem_req_valid_o), 64'(m_phase == 1));
        check_eq("mem_addr",    64'(mem_addr_o),      64'(m_addr));
        check_eq("mem_wdata",   64'(mem_wdata_o),     64'(m_wdata));
        check_eq("mem_we",      64'(mem_we_o),        64'(m_we));
        check_eq("mem_qos",     64'(mem_qos_o),       64'(m_qos));
        check_eq("grant_id",    64'(grant_id_o),      64'(m_gid));
        check_eq("lat_viol",    64'(lat_violation_o), 64'(e_viol));
        if (rst_i) return;
        reload = (m_phase == 0);
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid_i[i] && m_credit[i] > 0) reload = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_won[i] = (i == win);
            wt = int'(req_qos_i[i].weight);
            if (reload) m_credit[i] = m_won[i] ? ((wt > 0) ? wt - 1 : 0) : wt;
            else if (m_won[i] && m_credit[i] > 0) m_credit[i]--;
            if (!req_valid_i[i] || m_won[i]) begin
                m_age[i] = 0; m_fired[i] = 0;
            end else begin
                if (m_age[i] < AGE_SAT) m_age[i]++;
                if (e_viol[i]) m_fired[i] = 1;
            end
        end
        if (win >= 0) begin
            m_ptr = (win + 1) % NUM_REQ; m_gid = win; m_phase = 1;
            m_addr = req_addr_i[win*ADDR_W +: ADDR_W];
            m_wdata = req_wdata_i[win*DATA_W +: DATA_W];
            m_we = req_we_i[win]; m_qos = req_qos_i[win];
            $display("txn: grant req %0d addr %h we %0d qos_on %0d", win, m_addr, m_we, qos_enable_i);
        end else if (m_phase == 1 && mem_req_ready_i) begin
            m_phase = 2;
        end else if (m_phase == 2 && mem_rsp_valid_i) begin
            m_phase = 0;
            $display("txn: response to req %0d data %h", m_gid, mem_rsp_rdata_i);
        end
    endtask

    task automatic new_request(input int i);
        req_valid_i[i] = 1'b1;
        req_addr_i[i*ADDR_W +: ADDR_W]  = $urandom;
        req_wdata_i[i*DATA_W +: DATA_W] = $urandom;
        req_we_i[i] = 1'($urandom_range(0, 1));
        if (!fixed_qos) begin
            req_qos_i[i].level              = qos_level_e'($urandom_range(0, 3));
            req_qos_i[i].urgent             = ($urandom_range(0, 7) == 0);
            req_qos_i[i].weight             = 8'($urandom_range(0, 3));
            req_qos_i[i].max_latency_cycles = 16'($urandom_range(0, 12));
        end
    endtask

    task automatic gen_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_won[i]) req_valid_i[i] = 1'b0;
            if (!req_en[i]) req_valid_i[i] = 1'b0;
            else if (!req_valid_i[i]) begin
                if ($urandom_range(0, 99) < new_pct) new_request(i);
            end else if ($urandom_range(0, 99) < drop_pct) req_valid_i[i] = 1'b0;
        end
        mem_req_ready_i = ($urandom_range(0, 99) < ready_pct);
        mem_rsp_valid_i = ($urandom_range(0, 99) < rsp_pct);
        mem_rsp_rdata_i = $urandom;
        if (qos_mode == 2) qos_enable_i = 1'($urandom_range(0, 1));
        else qos_enable_i = (qos_mode == 1);
    endtask

    task automatic step(input bit gen, input bit rst_val);
        @(negedge clk_i);
        rst_i = rst_val;
        if (rst_val) begin
            req_valid_i = '0;
            mem_rsp_valid_i = 1'b1;
            mem_rsp_rdata_i = $urandom;
        end
        if (gen) gen_inputs();
        #1;
        eval_cycle();
    endtask

    task automatic set_knobs(input int np, input int dp, input int rp, input int sp, input int qm);
        new_pct = np; drop_pct = dp; ready_pct = rp; rsp_pct = sp; qos_mode = qm;
    endtask

    initial begin
        model_reset();
        fixed_qos = 0; req_en = '1;
        set_knobs(0, 0, 0, 0, 0);
        // Reset state
        step(0, 1);
        step(0, 1);
        step(0, 0);

        // Plain round-robin, all requesting, memory ready with immediate response
        set_knobs(100, 0, 100, 100, 0);
        repeat (16) step(1, 0);

        // Random traffic with QoS on
        set_knobs(30, 3, 70, 50, 1);
        repeat (300) step(1, 0);

        // Weighted credits: two requesters, weights 3 and 1, equal level, continuous
        fixed_qos = 1; req_en = 4'b0011;
        req_qos_i[0] = '{level: QOS_MEDIUM, urgent: 1'b0, weight: 8'd3, max_latency_cycles: 16'hFFFF};
        req_qos_i[1] = '{level: QOS_MEDIUM, urgent: 1'b0, weight: 8'd1, max_latency_cycles: 16'hFFFF};
        set_knobs(100, 0, 100, 100, 1);
        repeat (30) step(1, 0);

        // Memory stall; req1 waits and must report a single latency violation
        req_qos_i[0] = '{level: QOS_HIGH, urgent: 1'b0, weight: 8'd2, max_latency_cycles: 16'hFFFF};
        req_qos_i[1] = '{level: QOS_LOW,  urgent: 1'b0, weight: 8'd2, max_latency_cycles: 16'd8};
        set_knobs(100, 0, 0, 100, 1);
        repeat (20) step(1, 0);
        set_knobs(100, 0, 100, 100, 1);
        repeat (10) step(1, 0);

        // Reset while waiting for a response; late response must be ignored
        fixed_qos = 0; req_en = '1;
        set_knobs(100, 0, 100, 0, 1);
        for (int c = 0; c < 40 && m_phase != 2; c++) step(1, 0);
        check_eq("reach_wait_rsp", 64'(m_phase), 64'd2);
        step(0, 1);
        step(0, 1);
        step(0, 0);
        step(0, 0);

        // Random traffic with QoS toggling
        set_knobs(35, 5, 60, 50, 2);
        repeat (200) step(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
